// File: rtl/video_timing_gen.sv
`timescale 1ns/1ps
// video_timing_gen
//
// Raster timing generator. Free-running h/v counters on pixel_clk are decoded
// into registered pixel_de/hs/vs/x/y and frame_start (1-cycle latency from
// counter value to outputs). The timing in use lives in an active register set
// that resets to the parameters. A new set is requested with cfg_req (level)
// and is validated and loaded only at the frame-end cycle. After that, cfg_ack
// or cfg_err pulses for one cycle.
//
// Optional feature macro: VTG_POLARITY_EN
//   When defined, it adds cfg_hs_pol/cfg_vs_pol (1 = active-high). Both load
//   with the rest of the set. When undefined, both syncs are fixed active-low.
//
// Ports:
//   pixel_clk, reset_n         clock, async active-low reset
//   cfg_{h,v}_{total,sync,start,end}  requested timing (12 bits each)
//   cfg_req                    request level; cfg_ack / cfg_err result pulses
//   pixel_de/hs/vs/x/y         registered raster outputs
//   image_width/height         active h_end-h_start / v_end-v_start
//   frame_start                pulse with the outputs for position (0,0)
//   dbg_cfg_state              config FSM state (IDLE=0 PEND=1 DONE=2 WAIT_LOW=3)
//
// cfg_req/cfg_ack handshake: the requester raises cfg_req and holds cfg_* stable
// until it sees cfg_ack or cfg_err, then drops cfg_req. The FSM accepts no new
// request until cfg_req has been seen low. Dropping cfg_req before the frame end
// cancels the request silently.
module video_timing_gen #(
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_START = 144,
  parameter int unsigned H_END   = 784,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_START = 35,
  parameter int unsigned V_END   = 515
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  input  logic [11:0] cfg_h_total,
  input  logic [11:0] cfg_h_sync,
  input  logic [11:0] cfg_h_start,
  input  logic [11:0] cfg_h_end,
  input  logic [11:0] cfg_v_total,
  input  logic [11:0] cfg_v_sync,
  input  logic [11:0] cfg_v_start,
  input  logic [11:0] cfg_v_end,
  input  logic        cfg_req,
`ifdef VTG_POLARITY_EN
  input  logic        cfg_hs_pol,
  input  logic        cfg_vs_pol,
`endif
  output logic        cfg_ack,
  output logic        cfg_err,
  output logic        pixel_de,
  output logic        pixel_hs,
  output logic        pixel_vs,
  output logic [11:0] pixel_x,
  output logic [11:0] pixel_y,
  output logic [11:0] image_width,
  output logic [11:0] image_height,
  output logic        frame_start,
  output logic [1:0]  dbg_cfg_state
);

  localparam logic [11:0] H_TOTAL_C = 12'(H_TOTAL);
  localparam logic [11:0] H_SYNC_C  = 12'(H_SYNC);
  localparam logic [11:0] H_START_C = 12'(H_START);
  localparam logic [11:0] H_END_C   = 12'(H_END);
  localparam logic [11:0] V_TOTAL_C = 12'(V_TOTAL);
  localparam logic [11:0] V_SYNC_C  = 12'(V_SYNC);
  localparam logic [11:0] V_START_C = 12'(V_START);
  localparam logic [11:0] V_END_C   = 12'(V_END);

  typedef enum logic [1:0] {IDLE = 2'd0, PEND = 2'd1, DONE = 2'd2, WAIT_LOW = 2'd3} cfg_state_e;

  cfg_state_e  state_q, state_d;
  logic [11:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [11:0] h_total_q, h_sync_q, h_start_q, h_end_q;
  logic [11:0] v_total_q, v_sync_q, v_start_q, v_end_q;
  logic        hs_pol_q, vs_pol_q;
  logic        de_q, hs_q, vs_q, fs_q, ack_q, err_q;
  logic [11:0] x_q, y_q, width_q, height_q;
  logic        de_d, hs_d, vs_d, ack_d, err_d;
  logic [11:0] x_d, y_d;
  logic        line_end, frame_end, cfg_valid, load;
  logic        h_ok, v_ok, hs_act, vs_act;

  assign line_end  = (h_cnt_q == h_total_q - 12'd1);
  assign frame_end = line_end && (v_cnt_q == v_total_q - 12'd1);

  assign h_ok = (cfg_h_total >= 12'd2) && (cfg_h_sync >= 12'd1) &&
                (cfg_h_sync < cfg_h_start) && (cfg_h_start < cfg_h_end) &&
                (cfg_h_end <= cfg_h_total);
  assign v_ok = (cfg_v_total >= 12'd2) && (cfg_v_sync >= 12'd1) &&
                (cfg_v_sync < cfg_v_start) && (cfg_v_start < cfg_v_end) &&
                (cfg_v_end <= cfg_v_total);
  assign cfg_valid = h_ok && v_ok;

  // Config FSM: the decision is taken at the frame-end edge, so the result
  // pulse is visible during DONE, which is the first cycle of the new frame.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE:     if (cfg_req) state_d = PEND;
      PEND: begin
        if (!cfg_req) begin
          state_d = IDLE;
        end else if (frame_end) begin
          state_d = DONE;
          load    = cfg_valid;
          ack_d   = cfg_valid;
          err_d   = !cfg_valid;
        end
      end
      DONE:     state_d = WAIT_LOW;
      WAIT_LOW: if (!cfg_req) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // Counters and decode of the current position against the active set.
  always_comb begin
    h_cnt_d = h_cnt_q + 12'd1;
    v_cnt_d = v_cnt_q;
    if (line_end) begin
      h_cnt_d = 12'd0;
      v_cnt_d = (v_cnt_q == v_total_q - 12'd1) ? 12'd0 : v_cnt_q + 12'd1;
    end
    hs_act = (h_cnt_q < h_sync_q);
    vs_act = (v_cnt_q < v_sync_q);
    de_d   = (h_cnt_q >= h_start_q) && (h_cnt_q < h_end_q) &&
             (v_cnt_q >= v_start_q) && (v_cnt_q < v_end_q);
    x_d    = de_d ? h_cnt_q - h_start_q : 12'd0;
    y_d    = de_d ? v_cnt_q - v_start_q : 12'd0;
`ifdef VTG_POLARITY_EN
    hs_d   = hs_pol_q ? hs_act : !hs_act;
    vs_d   = vs_pol_q ? vs_act : !vs_act;
`else
    hs_d   = !hs_act;
    vs_d   = !vs_act;
`endif
  end

  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      h_cnt_q   <= 12'd0;
      v_cnt_q   <= 12'd0;
      h_total_q <= H_TOTAL_C;
      h_sync_q  <= H_SYNC_C;
      h_start_q <= H_START_C;
      h_end_q   <= H_END_C;
      v_total_q <= V_TOTAL_C;
      v_sync_q  <= V_SYNC_C;
      v_start_q <= V_START_C;
      v_end_q   <= V_END_C;
      hs_pol_q  <= 1'b0;
      vs_pol_q  <= 1'b0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      fs_q      <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      x_q       <= 12'd0;
      y_q       <= 12'd0;
      width_q   <= H_END_C - H_START_C;
      height_q  <= V_END_C - V_START_C;
    end else begin
      state_q  <= state_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      de_q     <= de_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      fs_q     <= (h_cnt_q == 12'd0) && (v_cnt_q == 12'd0);
      ack_q    <= ack_d;
      err_q    <= err_d;
      x_q      <= x_d;
      y_q      <= y_d;
      width_q  <= h_end_q - h_start_q;
      height_q <= v_end_q - v_start_q;
      if (load) begin
        h_total_q <= cfg_h_total;
        h_sync_q  <= cfg_h_sync;
        h_start_q <= cfg_h_start;
        h_end_q   <= cfg_h_end;
        v_total_q <= cfg_v_total;
        v_sync_q  <= cfg_v_sync;
        v_start_q <= cfg_v_start;
        v_end_q   <= cfg_v_end;
`ifdef VTG_POLARITY_EN
        hs_pol_q  <= cfg_hs_pol;
        vs_pol_q  <= cfg_vs_pol;
`endif
      end
    end
  end

  assign cfg_ack       = ack_q;
  assign cfg_err       = err_q;
  assign pixel_de      = de_q;
  assign pixel_hs      = hs_q;
  assign pixel_vs      = vs_q;
  assign pixel_x       = x_q;
  assign pixel_y       = y_q;
  assign image_width   = width_q;
  assign image_height  = height_q;
  assign frame_start   = fs_q;
  assign dbg_cfg_state = state_q;

endmodule

// File: tb/tb_video_timing_gen.sv
`timescale 1ns/1ps
// Bench for video_timing_gen with small default timing so full frames are short.
module tb_video_timing_gen;

  localparam int HT = 16, HS = 3, HST = 5, HE = 13;
  localparam int VT = 10, VS = 2, VST = 3, VE = 8;
  localparam int W  = 54;

  logic        pixel_clk = 1'b0;
  logic        reset_n   = 1'b0;
  logic [11:0] cfg_h_total, cfg_h_sync, cfg_h_start, cfg_h_end;
  logic [11:0] cfg_v_total, cfg_v_sync, cfg_v_start, cfg_v_end;
  logic        cfg_req = 1'b0;
  logic        cfg_hs_pol = 1'b0, cfg_vs_pol = 1'b0;
  logic        cfg_ack, cfg_err, pixel_de, pixel_hs, pixel_vs, frame_start;
  logic [11:0] pixel_x, pixel_y, image_width, image_height;
  logic [1:0]  dbg_cfg_state;

  video_timing_gen #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_START(HST), .H_END(HE),
    .V_TOTAL(VT), .V_SYNC(VS), .V_START(VST), .V_END(VE)
  ) dut (
    .pixel_clk(pixel_clk), .reset_n(reset_n),
    .cfg_h_total(cfg_h_total), .cfg_h_sync(cfg_h_sync),
    .cfg_h_start(cfg_h_start), .cfg_h_end(cfg_h_end),
    .cfg_v_total(cfg_v_total), .cfg_v_sync(cfg_v_sync),
    .cfg_v_start(cfg_v_start), .cfg_v_end(cfg_v_end),
    .cfg_req(cfg_req),
`ifdef VTG_POLARITY_EN
    .cfg_hs_pol(cfg_hs_pol), .cfg_vs_pol(cfg_vs_pol),
`endif
    .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .pixel_de(pixel_de), .pixel_hs(pixel_hs), .pixel_vs(pixel_vs),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .image_width(image_width), .image_height(image_height),
    .frame_start(frame_start), .dbg_cfg_state(dbg_cfg_state)
  );

  // Clock
  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    logic [11:0] ht, hs, hst, he, vt, vs, vst, ve;
    logic        hpol, vpol;
    logic        valid;
  } vec_t;

  vec_t vecs[7];
  vec_t cur;
  logic [W-1:0] exp_q[$];

  int n_checks = 0, n_fail = 0;
  // Reference raster model state
  int m_h, m_v, m_st;
  int m_ht, m_hs, m_hst, m_he, m_vt, m_vs, m_vst, m_ve, m_hpol, m_vpol;
  int cnt_de, cnt_hs_low, cnt_vs_low, cnt_fs;

  function automatic vec_t mk(input int ht, hs, hst, he, vt, vs, vst, ve, hp, ok);
    vec_t v;
    v.ht = 12'(ht); v.hs = 12'(hs); v.hst = 12'(hst); v.he = 12'(he);
    v.vt = 12'(vt); v.vs = 12'(vs); v.vst = 12'(vst); v.ve = 12'(ve);
    v.hpol = hp[0]; v.vpol = 1'b0; v.valid = ok[0];
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reset_model();
    m_h = 0; m_v = 0; m_st = 0;
    m_ht = HT; m_hs = HS; m_hst = HST; m_he = HE;
    m_vt = VT; m_vs = VS; m_vst = VST; m_ve = VE;
    m_hpol = 0; m_vpol = 0;
  endtask

  task automatic drive_cfg(input vec_t v);
    cur = v;
    cfg_h_total = v.ht; cfg_h_sync = v.hs; cfg_h_start = v.hst; cfg_h_end = v.he;
    cfg_v_total = v.vt; cfg_v_sync = v.vs; cfg_v_start = v.vst; cfg_v_end = v.ve;
    cfg_hs_pol = v.hpol; cfg_vs_pol = v.vpol;
  endtask

  task automatic check_reset_vals();
    check("reset_outputs",
          64'({pixel_de, pixel_hs, pixel_vs, frame_start, cfg_ack, cfg_err,
               pixel_x, pixel_y, image_width, image_height}),
          64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0, 12'd0,
               12'(HE - HST), 12'(VE - VST)}));
    check("reset_state", 64'(dbg_cfg_state), 64'd0);
  endtask

  // One clock: push the expected outputs for the current model position,
  // then compare after the edge and advance the model.
  task automatic step();
    logic fe, ld, de, hs, vs, fs;
    logic [11:0] x, y;
    logic [W-1:0] a;
    fe = (m_h == m_ht - 1) && (m_v == m_vt - 1);
    ld = (m_st == 1) && cfg_req && fe;
    de = (m_h >= m_hst) && (m_h < m_he) && (m_v >= m_vst) && (m_v < m_ve);
    hs = (m_hpol != 0) ? (m_h < m_hs) : !(m_h < m_hs);
    vs = (m_vpol != 0) ? (m_v < m_vs) : !(m_v < m_vs);
    fs = (m_h == 0) && (m_v == 0);
    x  = de ? 12'(m_h - m_hst) : 12'd0;
    y  = de ? 12'(m_v - m_vst) : 12'd0;
    exp_q.push_back({de, hs, vs, fs, ld && cur.valid, ld && !cur.valid, x, y,
                     12'(m_he - m_hst), 12'(m_ve - m_vst)});
    @(posedge pixel_clk);
    #1;
    a = {pixel_de, pixel_hs, pixel_vs, frame_start, cfg_ack, cfg_err,
         pixel_x, pixel_y, image_width, image_height};
    check("outputs", 64'(a), 64'(exp_q.pop_front()));
    cnt_de     += int'(pixel_de);
    cnt_hs_low += int'(!pixel_hs);
    cnt_vs_low += int'(!pixel_vs);
    cnt_fs     += int'(frame_start);
    case (m_st)
      0: if (cfg_req) m_st = 1;
      1: if (!cfg_req) m_st = 0; else if (fe) m_st = 2;
      2: m_st = 3;
      default: if (!cfg_req) m_st = 0;
    endcase
    if (m_h == m_ht - 1) begin
      m_h = 0;
      m_v = (m_v == m_vt - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    if (ld && cur.valid) begin
      m_ht = int'(cur.ht); m_hs = int'(cur.hs); m_hst = int'(cur.hst); m_he = int'(cur.he);
      m_vt = int'(cur.vt); m_vs = int'(cur.vs); m_vst = int'(cur.vst); m_ve = int'(cur.ve);
`ifdef VTG_POLARITY_EN
      m_hpol = int'(cur.hpol); m_vpol = int'(cur.vpol);
`endif
    end
  endtask

  // One default-timing frame from (0,0): aggregate counts from the parameters.
  task automatic count_frame();
    cnt_de = 0; cnt_hs_low = 0; cnt_vs_low = 0; cnt_fs = 0;
    repeat (HT * VT) step();
    check("frame_de_count", 64'(cnt_de), 64'((HE - HST) * (VE - VST)));
    check("frame_hs_low", 64'(cnt_hs_low), 64'(HS * VT));
    check("frame_vs_low", 64'(cnt_vs_low), 64'(VS * HT));
    check("frame_start_count", 64'(cnt_fs), 64'd1);
  endtask

  task automatic do_request(input vec_t v, input int lead);
    int budget;
    drive_cfg(v);
    repeat (lead) step();
    cfg_req = 1'b1;
    budget = 3 * m_ht * m_vt;
    while (!(cfg_ack || cfg_err) && budget > 0) begin
      step();
      budget--;
    end
    if (!(cfg_ack || cfg_err)) begin
      n_checks++;
      n_fail++;
      $display("FAIL req_timeout: got no ack/err expected a result pulse");
    end else begin
      check("req_result", 64'({cfg_ack, cfg_err}), v.valid ? 64'd2 : 64'd1);
    end
    cfg_req = 1'b0;
  endtask

  initial begin
    int n, budget;
    vec_t vdef;
    vdef    = mk(HT, HS, HST, HE, VT, VS, VST, VE, 0, 1);
    vecs[0] = mk(12, 2, 3, 11, 8, 1, 2, 7, 0, 1);   // smaller valid raster
    vecs[1] = mk(16, 3, 14, 13, 10, 2, 3, 8, 0, 0); // h_start >= h_end
    vecs[2] = mk(10, 1, 2, 10, 6, 1, 2, 6, 0, 1);   // end == total, sync == 1
    vecs[3] = mk(16, 0, 5, 13, 10, 2, 3, 8, 0, 0);  // sync == 0
    vecs[4] = mk(10, 1, 2, 10, 6, 1, 2, 7, 0, 0);   // v_end > v_total
    vecs[5] = mk(16, 5, 5, 13, 10, 2, 3, 8, 0, 0);  // sync == start
    vecs[6] = vdef;

    // Reset
    drive_cfg(vdef);
    reset_model();
    #12;
    check_reset_vals();
    @(negedge pixel_clk);
    reset_n = 1'b1;

    // First frame at default timing
    count_frame();

    // Table of requests, each raised mid-frame
    for (int i = 0; i < 7; i++) begin
      do_request(vecs[i], $urandom_range(5, 60));
      repeat (m_ht * m_vt + 4) step();
    end

    // Cancelled request: raised at frame start, dropped well before frame end
    budget = 1000;
    while (!(m_h == 0 && m_v == 0) && budget > 0) begin step(); budget--; end
    drive_cfg(vecs[0]);
    cfg_req = 1'b1;
    repeat (5) step();
    cfg_req = 1'b0;
    repeat (2 * m_ht * m_vt) step();
    check("cancel_width", 64'(image_width), 64'(HE - HST));

    // Request raised in the frame-end cycle waits a whole frame
    drive_cfg(vdef);
    budget = 1000;
    while (!(m_h == m_ht - 1 && m_v == m_vt - 1) && budget > 0) begin step(); budget--; end
    cfg_req = 1'b1;
    step();
    check("fe_req_pending", 64'({dbg_cfg_state, cfg_ack}), 64'({2'd1, 1'b0}));
    n = 0;
    while (!(cfg_ack || cfg_err) && n < 3 * HT * VT) begin step(); n++; end
    check("fe_req_delay", 64'(n), 64'(HT * VT));
    cfg_req = 1'b0;
    repeat (3) step();

    // 1080p request mid-frame
    do_request(mk(2200, 44, 192, 2112, 1125, 5, 41, 1121, 0, 1), $urandom_range(10, 100));
    step();
    check("hd_size", 64'({image_width, image_height, frame_start}), 64'({12'd1920, 12'd1080, 1'b1}));
    repeat (40) step();

    // Asynchronous reset mid-line with a request pending
    drive_cfg(vdef);
    cfg_req = 1'b1;
    repeat (3) step();
    #3;
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    cfg_req = 1'b0;
    exp_q.delete();
    reset_model();
    @(negedge pixel_clk);
    reset_n = 1'b1;
    count_frame();

    // Sync polarity request (active-high hs when the feature is built in)
    do_request(mk(HT, HS, HST, HE, VT, VS, VST, VE, 1, 1), 20);
    repeat (HT * VT + 4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
